design_checker: RTL and testbench

//   Downstream response checker for my_design. Takes the stimulus driven into the DUT
//   (data bit and DUT reset) plus all DUT outputs, and keeps a cycle-accurate model of
//   the expected responses. Runs a bounded check window and reports pass/fail, an error

---
 rtl/design_checker.sv | 161 ++++++++++++++++
 tb/tb_design_checker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/design_checker.sv
// design_checker: downstream response checker for my_design.
// Rebuilds the expected DUT response from the stimulus history, compares it with the
// DUT outputs over a bounded window and reports pass/fail, an error count and masks.
// Optional feature macro: DESIGN_CHECKER_ERRLOC_EN adds o_FirstErrCycle, the RUN index
// of the first failing cycle.
module design_checker #(
    parameter int unsigned CHECK_CYCLES = 256,
    parameter int unsigned CYC_W        = 16,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Start,
    input  logic             i_Stim,
    input  logic             i_DutReset,
    input  logic [3:0]       i_DataFF,
    input  logic             i_DataPassthrough,
    input  logic             i_DataOp,
    output logic             o_Busy,
    output logic             o_Done,
    output logic             o_Pass,
    output logic [ERR_W-1:0] o_ErrCount,
    output logic [6:0]       o_ErrMask,
`ifdef DESIGN_CHECKER_ERRLOC_EN
    output logic [6:0]       o_FirstErrMask,
    output logic [CYC_W-1:0] o_FirstErrCycle
`else
    output logic [6:0]       o_FirstErrMask
`endif
);

    localparam int unsigned CMP_W  = 6;
    localparam int unsigned MASK_W = 7;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CHECK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state;
    logic             warm_cnt;
    logic [CYC_W-1:0] run_cnt;

    logic s1;
    logic r1;
    logic s2x;
    logic s3;

    logic [CMP_W-1:0]  expected_c;
    logic [CMP_W-1:0]  actual_c;
    logic [MASK_W-1:0] mismatch_c;
    logic              any_mis_c;
    logic [ERR_W-1:0]  err_next_c;

    // Stimulus history, tracked in every state so WARMUP only has to let it settle
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            s1  <= 1'b0;
            r1  <= 1'b0;
            s2x <= 1'b0;
            s3  <= 1'b0;
        end else begin
            s1  <= i_Stim;
            r1  <= i_DutReset;
            s2x <= i_Stim & ~i_DutReset;
            s3  <= s2x;
        end
    end

    // Expected DUT response, mismatch vector and the saturating next error count
    always_comb begin
        expected_c = {~i_Stim, i_Stim, s3, s2x, ~s1, s1};
        actual_c   = {i_DataOp, i_DataPassthrough, i_DataFF};
        mismatch_c = {1'b0, actual_c ^ expected_c};
        any_mis_c  = |mismatch_c;
        err_next_c = o_ErrCount;
        if (any_mis_c && (o_ErrCount != '1)) begin
            err_next_c = o_ErrCount + ERR_W'(1);
        end
    end

    // Check-run sequencer with registered status and result outputs
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state           <= ST_IDLE;
            warm_cnt        <= 1'b0;
            run_cnt         <= '0;
            o_Busy          <= 1'b0;
            o_Done          <= 1'b0;
            o_Pass          <= 1'b0;
            o_ErrCount      <= '0;
            o_ErrMask       <= '0;
            o_FirstErrMask  <= '0;
`ifdef DESIGN_CHECKER_ERRLOC_EN
            o_FirstErrCycle <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_Start) begin
                        state           <= ST_WARMUP;
                        warm_cnt        <= 1'b0;
                        run_cnt         <= '0;
                        o_Busy          <= 1'b1;
                        o_Done          <= 1'b0;
                        o_Pass          <= 1'b0;
                        o_ErrCount      <= '0;
                        o_ErrMask       <= '0;
                        o_FirstErrMask  <= '0;
`ifdef DESIGN_CHECKER_ERRLOC_EN
                        o_FirstErrCycle <= '1;
`endif
                    end
                end
                ST_WARMUP: begin
                    // Two cycles so that s3 holds post-start stimulus at the first compare
                    if (warm_cnt) begin
                        state   <= ST_RUN;
                        run_cnt <= '0;
                    end else begin
                        warm_cnt <= 1'b1;
                    end
                end
                ST_RUN: begin
                    o_ErrCount <= err_next_c;
                    o_ErrMask  <= o_ErrMask | mismatch_c;
                    if (o_ErrCount == '0) begin
                        o_FirstErrMask <= mismatch_c;
`ifdef DESIGN_CHECKER_ERRLOC_EN
                        if (any_mis_c) begin
                            o_FirstErrCycle <= run_cnt;
                        end
`endif
                    end
                    if (run_cnt == LAST_CYC) begin
                        state  <= ST_DONE;
                        o_Busy <= 1'b0;
                        o_Done <= 1'b1;
                        o_Pass <= (err_next_c == '0);
                    end else begin
                        run_cnt <= run_cnt + CYC_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                    o_Done <= 1'b0;
                    o_Pass <= 1'b0;
                end
            endcase
        end
    end

    // r1 is part of the visible history but feeds no comparison
    logic unused_r1_c;
    assign unused_r1_c = r1;

endmodule

// File: tb/tb_design_checker.sv
// Bench for design_checker: emulates a correct my_design (with optional planted DUT
// faults), predicts checker outputs from logged stimulus and compares every cycle.
module tb_design_checker;

    localparam int C      = 256;
    localparam int CYC_W  = 16;
    localparam int ERR_W  = 8;
    localparam int LOGN   = 8192;
    localparam int ERRMAX = 255;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stim = 1'b0;
    logic dut_rst = 1'b0;
    logic [3:0] ff = 4'b0;
    logic pt = 1'b0;
    logic op = 1'b0;

    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [6:0]       err_mask;
    logic [6:0]       first_mask;
`ifdef DESIGN_CHECKER_ERRLOC_EN
    logic [CYC_W-1:0] first_cycle;
`endif

    design_checker #(.CHECK_CYCLES(C), .CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
        .i_Clock           (clk),
        .i_Reset_n         (rst_n),
        .i_Start           (start),
        .i_Stim            (stim),
        .i_DutReset        (dut_rst),
        .i_DataFF          (ff),
        .i_DataPassthrough (pt),
        .i_DataOp          (op),
        .o_Busy            (busy),
        .o_Done            (done),
        .o_Pass            (pass),
        .o_ErrCount        (err_count),
        .o_ErrMask         (err_mask),
`ifdef DESIGN_CHECKER_ERRLOC_EN
        .o_FirstErrMask    (first_mask),
        .o_FirstErrCycle   (first_cycle)
`else
        .o_FirstErrMask    (first_mask)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-edge log of what was presented to the checker
    bit       stim_log [LOGN];
    bit       dr_log   [LOGN];
    bit [5:0] act_log  [LOGN];
    int       edge_cnt = 0;

    // Model of a checker run: start edge plus aggregates over compare edges
    bit       started = 1'b0;
    int       ks = 0;
    int       m_cnt = 0;
    bit [6:0] m_emask = '0;
    bit [6:0] m_fmask = '0;
    int       m_fcyc = 0;

    function automatic bit [6:0] exp_mismatch(input int k);
        int  i0;
        int  i1;
        int  i2;
        bit  [5:0] e;
        i0 = k & (LOGN - 1);
        i1 = (k - 1) & (LOGN - 1);
        i2 = (k - 2) & (LOGN - 1);
        e[0] = stim_log[i1];
        e[1] = ~stim_log[i1];
        e[2] = stim_log[i1] & ~dr_log[i1];
        e[3] = stim_log[i2] & ~dr_log[i2];
        e[4] = stim_log[i0];
        e[5] = ~stim_log[i0];
        return {1'b0, act_log[i0] ^ e};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started = 1'b0;
        end else begin
            int k;
            int d;
            bit [6:0] mm;
            edge_cnt = edge_cnt + 1;
            k = edge_cnt & (LOGN - 1);
            stim_log[k] = stim;
            dr_log[k]   = dut_rst;
            act_log[k]  = {op, pt, ff};
            if (start && (!started || (edge_cnt - 1 - ks) >= C + 2)) begin
                started = 1'b1;
                ks      = edge_cnt;
                m_cnt   = 0;
                m_emask = '0;
                m_fmask = '0;
                m_fcyc  = (1 << CYC_W) - 1;
            end else if (started) begin
                d = edge_cnt - ks;
                if (d >= 3 && d <= C + 2) begin
                    mm = exp_mismatch(edge_cnt);
                    if (mm != 0) begin
                        if (m_cnt == 0) begin
                            m_fmask = mm;
                            m_fcyc  = d - 3;
                        end
                        if (m_cnt < ERRMAX) m_cnt = m_cnt + 1;
                    end
                    m_emask = m_emask | mm;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int  d;
        bit  e_busy;
        bit  e_done;
        d      = edge_cnt - ks;
        e_busy = started && (d <= C + 1);
        e_done = started && (d >= C + 2);
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("pass", 32'(pass), 32'(e_done && m_cnt == 0));
        check("err_count", 32'(err_count), started ? 32'(m_cnt) : 32'd0);
        check("err_mask", 32'(err_mask), started ? 32'(m_emask) : 32'd0);
        check("first_mask", 32'(first_mask), started ? 32'(m_fmask) : 32'd0);
`ifdef DESIGN_CHECKER_ERRLOC_EN
        check("first_cycle", 32'(first_cycle), started ? 32'(m_fcyc) : 32'd0);
`endif
    end

    // Emulated DUT controls and planted faults
    bit stim_const = 1'b0;
    int dr_mode = 0;
    bit ff3_stuck = 1'b0;
    int flip_edge = -1;

    task automatic drive(input bit st);
        int nk;
        int p1;
        int p2;
        @(negedge clk);
        start = st;
        stim = stim_const ? 1'b1 : 1'($urandom_range(0, 1));
        if (dr_mode == 0)      dut_rst = 1'b0;
        else if (dr_mode == 2) dut_rst = 1'b1;
        else                   dut_rst = ($urandom_range(0, 3) == 0);
        nk = edge_cnt + 1;
        p1 = (nk - 1) & (LOGN - 1);
        p2 = (nk - 2) & (LOGN - 1);
        ff[0] = stim_log[p1];
        ff[1] = ~stim_log[p1];
        ff[2] = stim_log[p1] & ~dr_log[p1];
        ff[3] = stim_log[p2] & ~dr_log[p2];
        pt = stim;
        op = ~stim;
        if (ff3_stuck) ff[3] = 1'b0;
        if (nk == flip_edge) op = ~op;
    endtask

    task automatic start_and_wait(input int flip_idx, input int mid_start);
        int ks_l;
        int lat;
        bit seen;
        seen = 1'b0;
        lat = 0;
        drive(1'b1);
        ks_l = edge_cnt + 1;
        flip_edge = (flip_idx >= 0) ? ks_l + 3 + flip_idx : -1;
        drive(1'b0);
        check("warmup_busy", 32'(busy), 32'd1);
        check("warmup_cleared_cnt", 32'(err_count), 32'd0);
        check("warmup_cleared_mask", 32'(err_mask), 32'd0);
        for (int i = 0; i < C + 20 && !seen; i++) begin
            drive(i == mid_start);
            if (done) begin
                seen = 1'b1;
                lat = edge_cnt - ks_l;
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        else       check("latency", 32'(lat), 32'(C + 2));
        flip_edge = -1;
        drive(1'b0);
    endtask

    initial begin
        repeat (3) drive(1'b0);
        rst_n = 1'b1;
        drive(1'b0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_errcnt", 32'(err_count), 32'd0);

        // 1: correct DUT, random stimulus
        start_and_wait(-1, -1);
        check("t1_pass", 32'(pass), 32'd1);
        check("t1_errcnt", 32'(err_count), 32'd0);

        // 2: FF[3] stuck low with constant stimulus saturates the counter
        stim_const = 1'b1;
        ff3_stuck  = 1'b1;
        start_and_wait(-1, -1);
        check("t2_errcnt", 32'(err_count), 32'd255);
        check("t2_first_mask", 32'(first_mask), 32'h08);
        check("t2_pass", 32'(pass), 32'd0);
        stim_const = 1'b0;
        ff3_stuck  = 1'b0;

        // 3: single flip of DataOp at RUN index 10
        start_and_wait(10, -1);
        check("t3_errcnt", 32'(err_count), 32'd1);
        check("t3_err_mask", 32'(err_mask), 32'h20);
        check("t3_first_mask", 32'(first_mask), 32'h20);
`ifdef DESIGN_CHECKER_ERRLOC_EN
        check("t3_first_cycle", 32'(first_cycle), 32'd10);
`endif

        // 4: DUT reset held / toggled, correct DUT must pass
        dr_mode = 2;
        stim_const = 1'b1;
        start_and_wait(-1, -1);
        check("t4a_pass", 32'(pass), 32'd1);
        dr_mode = 1;
        stim_const = 1'b0;
        start_and_wait(-1, -1);
        check("t4b_pass", 32'(pass), 32'd1);
        dr_mode = 0;

        // 5: async reset mid-RUN abandons the run, then a fresh run passes
        flip_edge = -1;
        drive(1'b1);
        drive(1'b0);
        repeat (100) drive(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        check("t5_rst_pass", 32'(pass), 32'd0);
        check("t5_rst_errcnt", 32'(err_count), 32'd0);
        repeat (2) drive(1'b0);
        rst_n = 1'b1;
        drive(1'b0);
        start_and_wait(-1, -1);
        check("t5_pass", 32'(pass), 32'd1);

        // 6: Start during RUN ignored; Start in DONE clears and reruns
        start_and_wait(5, 60);
        check("t6a_errcnt", 32'(err_count), 32'd1);
        start_and_wait(-1, -1);
        check("t6b_errcnt", 32'(err_count), 32'd0);
        check("t6b_pass", 32'(pass), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
